// File: rtl/adc_gate_sequencer.sv
// adc_gate_sequencer: capture-window sequencer ahead of the biquad8 filter pair.
// A capture edge starts a fixed sequence: pre-delay, pass GATE_LEN ADC beats,
// post-delay, then a reset pulse so the downstream biquads flush.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a capture rising edge, output forced to zero
// PRE    | pre-delay before the window opens
// GATE   | window open, ADC beats pass through to gate_tdata
// POST   | post-delay after the window closes
// RST    | bq_rst_o asserted to flush the downstream biquads
module adc_gate_sequencer #(
    parameter int PRE_DELAY  = 32,
    parameter int GATE_LEN   = 64,
    parameter int POST_DELAY = 64,
    parameter int RST_LEN    = 32,
    parameter int CNTBITS    = 16
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         capture_i,
    input  logic [127:0] adc_tdata,
    input  logic         adc_tvalid,
    output logic         adc_tready,
    output logic [127:0] gate_tdata,
    output logic         gate_tvalid,
    input  logic         gate_tready,
    output logic         bq_rst_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         missed_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_GATE,
        S_POST,
        S_RST
    } state_t;

    // Each state lasts exactly its parameter in cycles, so the counter loads N-1.
    localparam logic [CNTBITS-1:0] PRE_LD  = CNTBITS'(PRE_DELAY - 1);
    localparam logic [CNTBITS-1:0] GATE_LD = CNTBITS'(GATE_LEN - 1);
    localparam logic [CNTBITS-1:0] POST_LD = CNTBITS'(POST_DELAY - 1);
    localparam logic [CNTBITS-1:0] RST_LD  = CNTBITS'(RST_LEN - 1);

    state_t               state_q, state_d;
    logic [CNTBITS-1:0]   cnt_q, cnt_d;
    logic                 cap_q;
    logic                 missed_q, missed_d;
    logic                 done_d;
    logic                 trig;
    logic [127:0]         gate_q;
    logic                 bq_rst_q, busy_q, done_q, rdy_q;

    // The stream is free-running; the handshake inputs carry no information.
    logic                 unused_handshake;
    assign unused_handshake = adc_tvalid ^ gate_tready;

    assign trig = capture_i & ~cap_q;

    // Next-state, shared down-counter and missed-trigger flag.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        missed_d = missed_q;
        done_d   = 1'b0;
        if (state_q == S_IDLE) begin
            if (trig) begin
                state_d  = S_PRE;
                cnt_d    = PRE_LD;
                missed_d = 1'b0;
            end
        end else begin
            if (trig) begin
                missed_d = 1'b1;
            end
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNTBITS'(1);
            end else begin
                unique case (state_q)
                    S_PRE: begin
                        state_d = S_GATE;
                        cnt_d   = GATE_LD;
                    end
                    S_GATE: begin
                        state_d = S_POST;
                        cnt_d   = POST_LD;
                    end
                    S_POST: begin
                        state_d = S_RST;
                        cnt_d   = RST_LD;
                    end
                    default: begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                endcase
            end
        end
    end

    // State register and registered outputs; decoded flags come from state_d so
    // each output is a plain flop aligned with the state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cap_q    <= 1'b1;
            missed_q <= 1'b0;
            gate_q   <= '0;
            bq_rst_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cap_q    <= capture_i;
            missed_q <= missed_d;
            gate_q   <= (state_q == S_GATE) ? adc_tdata : '0;
            bq_rst_q <= (state_d == S_RST);
            busy_q   <= (state_d != S_IDLE);
            done_q   <= done_d;
            rdy_q    <= 1'b1;
        end
    end

    assign adc_tready  = rdy_q;
    assign gate_tvalid = rdy_q;
    assign gate_tdata  = gate_q;
    assign bq_rst_o    = bq_rst_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign missed_o    = missed_q;

endmodule

// File: tb/tb_adc_gate_sequencer.sv
// Bench for adc_gate_sequencer: two instances (test-plan parameters and all-ones),
// a timing model derived from the documented cycle formulas, and a gate-beat queue.
module tb_adc_gate_sequencer;

    localparam int NCYC = 70;

    logic         clk = 1'b0;
    logic         rstn;
    logic         cap;
    logic [127:0] adc;

    logic [127:0] td0, td1;
    logic         rdy0, vld0, bq0, busy0, done0, miss0;
    logic         rdy1, vld1, bq1, busy1, done1, miss1;

    always #5 clk = ~clk;

    adc_gate_sequencer #(
        .PRE_DELAY(4), .GATE_LEN(8), .POST_DELAY(4), .RST_LEN(3), .CNTBITS(8)
    ) u_dut0 (
        .aclk(clk), .aresetn(rstn), .capture_i(cap), .adc_tdata(adc),
        .adc_tvalid(1'b1), .adc_tready(rdy0), .gate_tdata(td0), .gate_tvalid(vld0),
        .gate_tready(1'b1), .bq_rst_o(bq0), .busy_o(busy0), .done_o(done0),
        .missed_o(miss0)
    );

    adc_gate_sequencer #(
        .PRE_DELAY(1), .GATE_LEN(1), .POST_DELAY(1), .RST_LEN(1), .CNTBITS(8)
    ) u_dut1 (
        .aclk(clk), .aresetn(rstn), .capture_i(cap), .adc_tdata(adc),
        .adc_tvalid(1'b1), .adc_tready(rdy1), .gate_tdata(td1), .gate_tvalid(vld1),
        .gate_tready(1'b1), .bq_rst_o(bq1), .busy_o(busy1), .done_o(done1),
        .missed_o(miss1)
    );

    typedef struct packed {
        int           c;
        logic [127:0] v;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];

    int pp[2] = '{4, 1};
    int gg[2] = '{8, 1};
    int oo[2] = '{4, 1};
    int rr[2] = '{3, 1};

    int n_tests = 0;
    int n_fail  = 0;
    int acc[2];
    bit miss_e[2];
    bit prev_cap;
    bit oor;
    int cyc;
    int scn;

    function automatic logic [127:0] pat(input int c);
        logic [31:0] w;
        w = c;
        return {~w, w ^ 32'hA5A5_5A5A, w, w + 32'h1000_0001};
    endfunction

    function automatic bit cap_at(input int s, input int c);
        case (s)
            0:       return (c >= 10 && c <= 12);
            1:       return (c >= 10 && c <= 59);
            2:       return (c >= 10 && c <= 11) || (c >= 20 && c <= 21) || (c >= 40 && c <= 41);
            3:       return (c >= 10 && c <= 11) || (c >= 30 && c <= 31);
            default: return (c >= 10 && c <= 11) || (c >= 16 && c <= 30) || (c >= 40 && c <= 42);
        endcase
    endfunction

    function automatic bit rst_at(input int s, input int c);
        return (c < 3) || (s == 4 && c >= 18 && c <= 20);
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s scn%0d cyc%0d got=%h exp=%h", tag, scn, cyc, got, exp);
        end
    endtask

    task automatic check_inst(input int i, input logic [127:0] td, input logic bq,
                              input logic busy, input logic done, input logic miss,
                              input logic rdy, input logic vld);
        int d, tot, bq_lo;
        logic [127:0] eg;
        bit busy_e, bq_e, done_e;
        tot    = pp[i] + gg[i] + oo[i] + rr[i];
        bq_lo  = pp[i] + gg[i] + oo[i] + 1;
        d      = cyc - acc[i];
        eg     = '0;
        if (i == 0) begin
            if (q0.size() > 0 && q0[0].c == cyc) eg = q0.pop_front().v;
        end else begin
            if (q1.size() > 0 && q1[0].c == cyc) eg = q1.pop_front().v;
        end
        busy_e = rstn && d >= 1 && d <= tot;
        bq_e   = rstn && d >= bq_lo && d <= tot;
        done_e = rstn && d == tot + 1;
        chk($sformatf("gate%0d", i),   td,   rstn ? eg : '0);
        chk($sformatf("bq_rst%0d", i), bq,   bq_e);
        chk($sformatf("busy%0d", i),   busy, busy_e);
        chk($sformatf("done%0d", i),   done, done_e);
        chk($sformatf("missed%0d", i), miss, rstn && miss_e[i]);
        chk($sformatf("tready%0d", i), rdy,  oor);
        chk($sformatf("tvalid%0d", i), vld,  oor);
    endtask

    task automatic step_model(input int i, input bit trig);
        int    d, tot;
        beat_t b;
        tot = pp[i] + gg[i] + oo[i] + rr[i];
        d   = cyc - acc[i];
        if (!rstn) begin
            acc[i]    = -1000;
            miss_e[i] = 1'b0;
            if (i == 0) q0.delete();
            else        q1.delete();
        end else if (trig) begin
            if (d >= 1 && d <= tot) begin
                miss_e[i] = 1'b1;
            end else begin
                acc[i]    = cyc;
                miss_e[i] = 1'b0;
                for (int k = 0; k < gg[i]; k++) begin
                    b.c = cyc + pp[i] + 2 + k;
                    b.v = pat(b.c - 1);
                    if (i == 0) q0.push_back(b);
                    else        q1.push_back(b);
                end
            end
        end
    endtask

    initial begin
        bit trig;
        rstn     = 1'b0;
        cap      = 1'b0;
        adc      = '0;
        oor      = 1'b0;
        prev_cap = 1'b1;
        acc      = '{-1000, -1000};
        miss_e   = '{1'b0, 1'b0};
        for (int s = 0; s < 5; s++) begin
            scn = s;
            for (int c = 0; c < NCYC; c++) begin
                @(posedge clk);
                #1;
                cyc = c;
                if (rstn) oor = 1'b1;
                rstn = !rst_at(s, c);
                if (!rstn) oor = 1'b0;
                cap = cap_at(s, c);
                adc = pat(c);
                @(negedge clk);
                check_inst(0, td0, bq0, busy0, done0, miss0, rdy0, vld0);
                check_inst(1, td1, bq1, busy1, done1, miss1, rdy1, vld1);
                trig = rstn && cap && !prev_cap;
                step_model(0, trig);
                step_model(1, trig);
                prev_cap = rstn ? cap : 1'b1;
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
